// File: rtl/afifo_read_checker.sv
// Read-domain FIFO drain that checks popped words against an incrementing sequence.
// Pop has zero added latency (rinc_o is combinational); stalls on empty, throttle mask or stop.
module afifo_read_checker #(
  parameter int DSIZE = 16,
  parameter int CNTW  = 32
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [DSIZE-1:0] seed_i,
  input  logic [CNTW-1:0]  target_i,
  input  logic [7:0]       throttle_i,
  input  logic             rempty_i,
  input  logic [DSIZE-1:0] rdata_i,
  output logic             rinc_o,
  output logic [1:0]       state_o,
  output logic [CNTW-1:0]  nrecv_o,
  output logic [CNTW-1:0]  nerr_o,
  output logic             err_o,
  output logic [DSIZE-1:0] first_exp_o,
  output logic [DSIZE-1:0] first_got_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       phase;
  logic [DSIZE-1:0] expected;
  logic [CNTW-1:0]  nrecv, nerr;
  logic [CNTW-1:0]  nrecv_inc, nerr_inc;
  logic             err;
  logic [DSIZE-1:0] first_exp, first_got;
  logic             pop, mismatch, start_act;

  assign pop       = (state == RUN) & ~rempty_i & throttle_i[phase] & ~stop_i;
  assign mismatch  = rdata_i != expected;
  assign nrecv_inc = (&nrecv) ? nrecv : nrecv + CNTW'(1);
  assign nerr_inc  = (&nerr) ? nerr : nerr + CNTW'(1);

  // Stop beats start in DONE too, so a simultaneous pair lands cleanly in IDLE.
  assign start_act = start_i & ((state == IDLE) | ((state == DONE) & ~stop_i));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i) state_nxt = RUN;
      RUN: begin
        if (stop_i)
          state_nxt = IDLE;
        else if (pop && (target_i != '0) && (nrecv_inc == target_i))
          state_nxt = DONE;
      end
      DONE: begin
        if (stop_i)       state_nxt = IDLE;
        else if (start_i) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      expected  <= '0;
      nrecv     <= '0;
      nerr      <= '0;
      err       <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
    end else begin
      state <= state_nxt;
      if (start_act) begin
        expected  <= seed_i;
        phase     <= '0;
        nrecv     <= '0;
        nerr      <= '0;
        err       <= 1'b0;
        first_exp <= '0;
        first_got <= '0;
      end else begin
        if (state == RUN) phase <= phase + 3'd1;
        // Expected advances blindly; a dropped word shows up as a run of errors.
        if (pop) begin
          nrecv    <= nrecv_inc;
          expected <= expected + DSIZE'(1);
          if (mismatch) begin
            nerr <= nerr_inc;
            if (!err) begin
              err       <= 1'b1;
              first_exp <= expected;
              first_got <= rdata_i;
            end
          end
        end
      end
    end
  end

  assign rinc_o      = pop;
  assign state_o     = state;
  assign nrecv_o     = nrecv;
  assign nerr_o      = nerr;
  assign err_o       = err;
  assign first_exp_o = first_exp;
  assign first_got_o = first_got;

endmodule

// File: tb/tb_afifo_read_checker.sv
// Directed bench for afifo_read_checker with a queue standing in for the FIFO.
module tb_afifo_read_checker;

  logic        rclk = 1'b0;
  logic        reset;
  logic        start_i, stop_i;
  logic [15:0] seed_i;
  logic [31:0] target_i;
  logic [7:0]  throttle_i;
  logic        rempty_i;
  logic [15:0] rdata_i;
  logic        rinc_o;
  logic [1:0]  state_o;
  logic [31:0] nrecv_o, nerr_o;
  logic        err_o;
  logic [15:0] first_exp_o, first_got_o;

  logic [15:0] q[$];
  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  logic        last_p;
  logic [7:0]  pat;
  int          p0;

  afifo_read_checker #(.DSIZE(16), .CNTW(32)) dut (
    .rclk(rclk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .seed_i(seed_i), .target_i(target_i), .throttle_i(throttle_i),
    .rempty_i(rempty_i), .rdata_i(rdata_i), .rinc_o(rinc_o),
    .state_o(state_o), .nrecv_o(nrecv_o), .nerr_o(nerr_o), .err_o(err_o),
    .first_exp_o(first_exp_o), .first_got_o(first_got_o)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    rempty_i = (q.size() == 0);
    rdata_i  = (q.size() != 0) ? q[0] : 16'h0;
  endtask

  // Inputs change only 1ns after an edge; rinc_o is sampled once settled.
  task automatic tick();
    #1;
    last_p = rinc_o;
    if (last_p) pops++;
    @(posedge rclk);
    #1;
    if (last_p && q.size() != 0) void'(q.pop_front());
    refresh();
  endtask

  task automatic do_start(input logic [15:0] seed, input logic [31:0] tgt);
    seed_i = seed; target_i = tgt; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; stop_i = 1'b0; seed_i = '0;
    target_i = '0; throttle_i = 8'hFF;
    refresh();
    repeat (3) tick();
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_rinc", rinc_o, 0);
    chk("rst_nrecv", nrecv_o, 0);
    chk("rst_nerr", nerr_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_fexp", first_exp_o, 0);
    chk("rst_fgot", first_got_o, 0);
    reset = 1'b0;

    // Ten back-to-back pops, two spare words must stay in the FIFO.
    for (int i = 5; i <= 16; i++) q.push_back(16'(i));
    refresh();
    do_start(16'h0005, 32'd10);
    pops = 0;
    repeat (10) tick();
    chk("b2b_state", state_o, 2);
    chk("b2b_nrecv", nrecv_o, 10);
    repeat (5) tick();
    chk("b2b_pops", pops, 10);
    chk("b2b_left", q.size(), 2);
    chk("b2b_nerr", nerr_o, 0);
    #1 chk("done_rinc", rinc_o, 0);

    // Expected sequence wraps through zero without error.
    q.delete();
    q.push_back(16'hFFFE); q.push_back(16'hFFFF);
    q.push_back(16'h0000); q.push_back(16'h0001);
    refresh();
    do_start(16'hFFFE, 32'd4);
    repeat (6) tick();
    chk("wrap_nerr", nerr_o, 0);
    chk("wrap_state", state_o, 2);
    chk("wrap_nrecv", nrecv_o, 4);

    // Single bad word, expected keeps advancing.
    q.delete();
    q.push_back(16'd5); q.push_back(16'd7); q.push_back(16'd7);
    refresh();
    do_start(16'h0005, 32'd3);
    repeat (5) tick();
    chk("err_nerr", nerr_o, 1);
    chk("err_flag", err_o, 1);
    chk("err_fexp", first_exp_o, 16'h0006);
    chk("err_fgot", first_got_o, 16'h0007);
    chk("err_nrecv", nrecv_o, 3);

    // Throttle mask 0x55: pop on even phases only.
    q.delete();
    for (int i = 100; i < 140; i++) q.push_back(16'(i));
    refresh();
    throttle_i = 8'h55;
    do_start(16'd100, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      pat[i] = last_p;
    end
    chk("thr55_pat", pat, 8'h55);
    chk("thr55_nrecv", nrecv_o, 4);
    chk("thr55_nerr", nerr_o, 0);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    chk("stop1_state", state_o, 0);

    throttle_i = 8'h00;
    do_start(16'd0, 32'd0);
    repeat (8) tick();
    chk("thr00_nrecv", nrecv_o, 0);
    chk("thr00_state", state_o, 1);
    stop_i = 1'b1; tick(); stop_i = 1'b0;

    // Empty stall, then stop, then reset out of RUN.
    q.delete();
    q.push_back(16'd200); q.push_back(16'd201);
    refresh();
    throttle_i = 8'hFF;
    do_start(16'd200, 32'd0);
    repeat (2) tick();
    chk("emp_pre", nrecv_o, 2);
    p0 = pops;
    repeat (5) tick();
    chk("emp_pops", pops - p0, 0);
    chk("emp_nrecv", nrecv_o, 2);
    q.push_back(16'd202); q.push_back(16'd203);
    refresh();
    stop_i = 1'b1;
    #1 chk("stop_rinc", rinc_o, 0);
    tick();
    stop_i = 1'b0;
    chk("stop_state", state_o, 0);
    chk("stop_left", q.size(), 2);
    chk("stop_nrecv", nrecv_o, 2);

    do_start(16'd210, 32'd0);
    tick();
    chk("mid_err", err_o, 1);
    chk("mid_fgot", first_got_o, 16'd202);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_state", state_o, 0);
    chk("mrst_rinc", rinc_o, 0);
    chk("mrst_nrecv", nrecv_o, 0);
    chk("mrst_nerr", nerr_o, 0);
    chk("mrst_err", err_o, 0);
    chk("mrst_fexp", first_exp_o, 0);
    chk("mrst_fgot", first_got_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
